// File: rtl/i2c_pkg.sv
// Shared I2C constants: default received-word width, default RX FIFO depth,
// and the pointer-width helper used by the I2C slave side.
package i2c_pkg;

   localparam int I2C_WORD_WIDTH = 32;
   localparam int I2C_FIFO_DEPTH = 8;

   // Address width for a power-of-two buffer; never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/i2c_fifo_ram.sv
// Storage array for the I2C RX word FIFO: one synchronous write port and
// one asynchronous read port. Array contents are intentionally not reset.
module i2c_fifo_ram #(
   parameter int W     = 32,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/i2c_rx_word_fifo.sv
// Show-ahead word FIFO between the I2C slave receiver and its consumer.
// Defining I2C_RX_FIFO_PARITY_EN adds a per-word even-parity bit and perr.
module i2c_rx_word_fifo
   import i2c_pkg::*;
#(
   parameter int WIDTH = I2C_WORD_WIDTH,
   parameter int DEPTH = I2C_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_stb,
   input  logic [WIDTH-1:0]       wr_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [WIDTH-1:0]       rd_data,
   input  logic                   flush,
   input  logic                   ovf_clr,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   ovf
`ifdef I2C_RX_FIFO_PARITY_EN
   ,
   output logic                   perr
`endif
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
`ifdef I2C_RX_FIFO_PARITY_EN
   localparam int MW = WIDTH + 1;
`else
   localparam int MW = WIDTH;
`endif

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          push, pop, drop;
   logic [MW-1:0] ram_wdata, ram_rdata;

   assign full     = (count_q == CW'(DEPTH));
   assign rd_valid = (count_q != '0);
   // An empty FIFO never pops, so a same-cycle push with rd_ready is stored.
   assign pop      = rd_valid & rd_ready;
   assign push     = wr_stb & (~full | pop);
   assign drop     = wr_stb & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
         // A new drop wins over a coincident clear.
         if (drop)         ovf_d = 1'b1;
         else if (ovf_clr) ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef I2C_RX_FIFO_PARITY_EN
   assign ram_wdata = {^wr_data, wr_data};
   assign perr      = rd_valid & ((^ram_rdata[WIDTH-1:0]) != ram_rdata[WIDTH]);
`else
   assign ram_wdata = wr_data;
`endif

   i2c_fifo_ram #(
      .W     (MW),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clk   (clk),
      .we    (push & ~flush),
      .waddr (wr_ptr_q),
      .wdata (ram_wdata),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   assign rd_data = ram_rdata[WIDTH-1:0];
   assign count   = count_q;
   assign ovf     = ovf_q;

endmodule

// File: doc/i2c_rx_word_fifo.md
I2C_RX_WORD_FIFO -- requirements
Module: i2c_rx_word_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, bit width of one received I2C word.
REQ-002 SHALL provide parameter DEPTH, default 8, number of word entries; a power of two, 2 to 256.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_stb  input  1  one-cycle strobe from the I2C slave: a complete word has been received.
REQ-006 SHALL have port wr_data  input  WIDTH  received word (slave data_send), sampled when wr_stb=1.
REQ-007 SHALL have port rd_valid  output  1  head word available.
REQ-008 SHALL have port rd_ready  input  1  consumer accepts the head word.
REQ-009 SHALL have port rd_data  output  WIDTH  head word; valid only while rd_valid=1.
REQ-010 SHALL have port flush  input  1  synchronous discard of all contents.
REQ-011 SHALL have port ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-013 SHALL have port full  output  1  count==DEPTH.
REQ-014 SHALL have port ovf  output  1  sticky flag: a word was dropped.

Function
REQ-015 SHALL store words in a DEPTH-entry circular buffer with write pointer, read pointer and occupancy counter.
REQ-016 SHALL accept a push on the clock edge where wr_stb=1 and (full=0 or a pop occurs in the same cycle).
REQ-017 SHALL pop on the clock edge where rd_valid=1 and rd_ready=1.
REQ-018 SHALL drive rd_valid=(count!=0) and rd_data=entry[rd_ptr] (show-ahead); a word pushed into an empty FIFO appears on rd_data/rd_valid one cycle after the push edge.
REQ-019 SHALL NOT bypass: with count=0, a push plus rd_ready in the same cycle stores the word; no pop occurs.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop; both pointers advance.
REQ-021 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-022 SHALL drop wr_data when wr_stb=1, full=1 and no pop occurs; contents unchanged; ovf set to 1 on that edge.
REQ-023 SHALL hold ovf at 1 until ovf_clr=1, flush=1 or reset; if ovf_clr and a new drop coincide, ovf remains 1.
REQ-024 SHALL on flush=1 set pointers and count to 0 and clear ovf; a same-cycle push or pop is ignored.
REQ-025 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.

Reset
REQ-026 SHALL on rst=1 immediately clear pointers and count; rd_valid=0, full=0, ovf=0, count=0, and in parity builds perr=0.
REQ-027 SHALL discard all stored words on a reset mid-operation; storage array contents need not be reset.
REQ-028 SHALL ignore wr_stb, rd_ready, flush and ovf_clr while rst=1.

Configuration
REQ-029 SHALL, when macro I2C_RX_FIFO_PARITY_EN is defined, store one even-parity bit per word at push and add output perr (1 bit) = recomputed parity of the head entry differs from the stored bit, qualified by rd_valid.
REQ-030 SHALL, when I2C_RX_FIFO_PARITY_EN is undefined, have no parity storage and no perr port; all other behaviour is identical.

Structure
REQ-031 SHALL take the default WIDTH/DEPTH constants and the pointer-width function from the shared i2c package used by i2c_slave.
REQ-032 SHALL contain one sub-module, i2c_fifo_ram (dual-port, one write and one asynchronous read), holding the storage array.

Verification
REQ-033 SHALL cover: reset, then push 0xAABBCC0F -> one cycle later rd_valid=1, rd_data=0xAABBCC0F, count=1.
REQ-034 SHALL cover: push 8 words 0..7 with rd_ready=0 -> full=1, count=8; 9th push 0xDEAD -> ovf=1; drain yields 0..7 in order, no 0xDEAD.
REQ-035 SHALL cover: full FIFO with push 0x11 and rd_ready=1 in one cycle -> count stays 8, ovf stays 0, 0x11 is read last.
REQ-036 SHALL cover: 20 sequential push/pop pairs across pointer wrap -> read order equals write order; count never exceeds 1.
REQ-037 SHALL cover: count=5 with ovf=1, then flush -> next cycle count=0, rd_valid=0, ovf=0; assert rst mid-push -> all outputs 0 immediately.
REQ-038 SHALL cover, in a build with I2C_RX_FIFO_PARITY_EN, corrupting one stored bit via hierarchical force -> perr=1 while that word is at the head.
